groestl_core_arbiter: RTL
=========================

// Module: groestl_core_arbiter
// PURPOSE
//  Shares one Groestl hash core (64-bit src/dst stream handshake) among NREQ requesters.
//  Grants the core to one requester at a time, round-robin.
//  The grant is locked from grant until the full digest (HS/64 dst_write beats) has been returned to the owner.
//  Sits between the per-channel message feeders and the single groestl_top_pq_parallel instance.
// PARAMETERS
//  NREQ           4     number of requesters, 2..8
//  HS             512   digest size in bits, 256 or 512; OUT_WORDS = HS/64
//  TIMEOUT_CYCLES 4096  owner inactivity limit; used only with GROESTL_ARB_TIMEOUT_EN
// PORTS
//  clk             in   1        clock
//  reset           in   1        synchronous, active-high
//  req_valid       in   NREQ     requester i has a 64-bit word on req_data[64i+:64]
//  req_data        in   64*NREQ  message words; requester i uses slice [64i+:64]
//  req_ack         out  NREQ     word of requester i consumed this cycle
//  res_write       out  NREQ     digest word for requester i is valid on res_data
//  res_data        out  64       digest word, core order
//  grant_id        out  3        current owner index; valid while busy=1
//  busy            out  1        core is owned
//  err_timeout     out  1        sticky; owner timed out; cleared by reset (timeout build only)
//  core_rst        out  1        core reset = reset | abort pulse
//  core_src_ready  out  1        active-low; 0 = word available to the core
//  core_src_read   in   1        core consumed core_din
//  core_din        out  64       = req_data slice of owner
//  core_dst_ready  out  1        active-low; held 0 (results always accepted)
//  core_dst_write  in   1        core presents a digest word on core_dout
//  core_dout       in   64       digest word
// BEHAVIOUR
//  - Reset: state IDLE, rr_ptr=0, grant_id=0, busy=0, req_ack=0, res_write=0, res_data=0, err_timeout=0,
//    core_src_ready=1, core_rst=1 for the whole reset.
//  - FSM IDLE -> OWN -> IDLE.
//  - IDLE: pick the first i with req_valid[i], searching from rr_ptr upward modulo NREQ.
//    If found: grant_id<=i, busy<=1, state<=OWN at the next edge.
//    No request: stay in IDLE. The core is never driven from IDLE.
//  - OWN: core_src_ready = ~req_valid[grant_id] (combinational).
//    core_din = owner slice.
//    req_ack[grant_id] = core_src_read (combinational, zero latency); all other req_ack = 0.
//  - Requester contract: once req_valid is raised, valid and data are held until req_ack.
//    The owner may deassert req_valid between words; the grant is kept.
//  - Output path: on each core_dst_write in OWN, register res_data<=core_dout and res_write[grant_id]<=1.
//    The output therefore lags core_dst_write by 1 cycle. out_cnt increments on each core_dst_write.
//  - Release: on the core_dst_write with out_cnt==OUT_WORDS-1, at the next edge:
//    state<=IDLE, busy<=0, out_cnt<=0, rr_ptr<=(grant_id+1) mod NREQ.
//    The next grant is issued no earlier than 1 cycle later, so there is at least 1 idle cycle between owners.
//  - Simultaneous events:
//    - Requests arriving during OWN wait their turn.
//    - A request from the current owner in the release cycle is not re-granted ahead of others; rr_ptr has already moved past it.
//    - core_dst_write in IDLE is ignored: no res_write, no count.
//    - core_src_read while core_src_ready=1 is ignored: no ack.
//  - reset mid-message: returns to the reset state immediately. The core is reset via core_rst.
//    Partial digests are never delivered.
//  - grant_id is zero-extended to 3 bits for NREQ<8.
// CONFIGURATION
//  - GROESTL_ARB_TIMEOUT_EN defined:
//    - A 16-bit idle counter in OWN clears on any core_src_read or core_dst_write.
//    - When it reaches TIMEOUT_CYCLES: abort. core_rst pulses 1 cycle, err_timeout<=1, the release actions run, no res_write.
//  - GROESTL_ARB_TIMEOUT_EN not defined: no counter, err_timeout tied 0, core_rst = reset.
// STRUCTURE
//  - Package groestl_arb_pkg: FSM state enum (S_IDLE, S_OWN), OUT_WORDS(HS) function, GRANT_W=3 constant.
//  - One sub-module, groestl_rr_pick: combinational round-robin picker.
//    Inputs (req, ptr); outputs (found, idx).
// TESTING
//  - Single requester, NREQ=4, HS=512, req 2 streams 16 words:
//    -> 16 req_ack[2] pulses, 8 res_write[2] beats with res_data equal to core_dout,
//    -> busy drops 1 cycle after the 8th beat, rr_ptr=3.
//  - All four req_valid high from reset:
//    -> grant order 0,1,2,3,0 with >=1 IDLE cycle between grants; no req_ack to non-owners.
//  - Owner drops req_valid mid-message for 10 cycles:
//    -> core_src_ready=1 for those cycles, grant held, message completes normally.
//  - reset asserted after 5 words of owner 1:
//    -> busy=0, core_rst=1, no res_write; after reset, req 1 is granted first (rr_ptr=0 search hits 1 if req 0 idle).
//  - HS=256: exactly 4 res_write beats, release after the 4th; a stray core_dst_write in IDLE produces no res_write.
//  - GROESTL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, core stalls:
//    -> after 64 idle cycles core_rst pulses 1 cycle, err_timeout=1, the next requester is granted.

Source files
------------

// File: rtl/groestl_arb_pkg.sv
// Shared types and constants for the Groestl core arbiter.
package groestl_arb_pkg;

  typedef enum logic {S_IDLE, S_OWN} arb_state_e;

  localparam int unsigned GRANT_W = 3;

  function automatic int unsigned out_words(input int unsigned hs);
    return hs / 64;
  endfunction

endpackage

// File: rtl/groestl_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
module groestl_rr_pick
  import groestl_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               found,
  output logic [GRANT_W-1:0] idx
);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    // Walk from the farthest candidate down so the nearest one to ptr wins.
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % int'(NREQ);
      if (req[j]) begin
        found = 1'b1;
        idx   = GRANT_W'(j);
      end
    end
  end

endmodule

// File: rtl/groestl_core_arbiter.sv
// Round-robin arbiter sharing one Groestl core; the grant is locked until the full digest returns.
// Optional owner-inactivity abort is enabled by defining GROESTL_ARB_TIMEOUT_EN.
module groestl_core_arbiter
  import groestl_arb_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned HS             = 512,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [64*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      res_write,
  output logic [63:0]          res_data,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 core_rst,
  output logic                 core_src_ready,
  input  logic                 core_src_read,
  output logic [63:0]          core_din,
  output logic                 core_dst_ready,
  input  logic                 core_dst_write,
  input  logic [63:0]          core_dout
);

  localparam int unsigned OUT_WORDS = out_words(HS);
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(OUT_WORDS - 1);
  localparam logic [GRANT_W-1:0] LAST_REQ  = GRANT_W'(NREQ - 1);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [NREQ-1:0]    res_write_q, res_write_d;
  logic [63:0]        res_data_q, res_data_d;

  logic               pick_found;
  logic [GRANT_W-1:0] pick_idx;
  logic [IDX_W-1:0]   owner_idx;
  logic [63:0]        owner_data;
  logic [GRANT_W-1:0] next_ptr;
  logic               own;
  logic               owner_valid;
  logic               abort;

  groestl_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own         = (state_q == S_OWN);
  assign owner_idx   = grant_q[IDX_W-1:0];
  assign owner_valid = req_valid[owner_idx];
  assign owner_data  = req_data[{owner_idx, 6'b0} +: 64];
  assign next_ptr    = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    out_cnt_d   = out_cnt_q;
    res_write_d = '0;
    res_data_d  = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (core_dst_write) begin
          res_write_d[owner_idx] = 1'b1;
          res_data_d             = core_dout;
          out_cnt_d              = out_cnt_q + 1'b1;
        end
        // Last digest beat or an abort hands the core back; rr_ptr skips past the owner.
        if ((core_dst_write && out_cnt_q == LAST_BEAT) || abort) begin
          state_d   = S_IDLE;
          out_cnt_d = '0;
          rr_ptr_d  = next_ptr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_cnt_q   <= '0;
      res_write_q <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_cnt_q   <= out_cnt_d;
      res_write_q <= res_write_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    req_ack = '0;
    if (own && owner_valid) req_ack[owner_idx] = core_src_read;
  end

  assign res_write      = res_write_q;
  assign res_data       = res_data_q;
  assign grant_id       = grant_q;
  assign busy           = own;
  assign core_src_ready = ~(own & owner_valid);
  assign core_din       = own ? owner_data : '0;
  assign core_dst_ready = 1'b0;

`ifdef GROESTL_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_cnt_q;
  logic        abort_q;
  logic        err_q;

  assign abort = own & ~core_src_read & ~core_dst_write & (idle_cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= '0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (!own || core_src_read || core_dst_write || abort) idle_cnt_q <= '0;
      else                                                  idle_cnt_q <= idle_cnt_q + 1'b1;
      abort_q <= abort;
      if (abort) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
  assign core_rst    = reset | abort_q;
`else
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_LAST;
  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
  assign core_rst    = reset;
`endif

endmodule
